// File: rtl/memory_bank.sv
// memory_bank: parametrised single-port word store with registered reads, sequenced
// whole-bank clear and a chip-select-gated tri-state output. MEM_PARITY_EN adds per-word even parity.
module memory_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  I,
    input  logic              write,
    input  logic              read,
    input  logic              clear,
    output logic [WIDTH-1:0]  O,
    output logic              rd_valid,
    output logic              busy,
    output logic              perr
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_data_p1;
    logic              vld_p1;

    logic cmd_ok;
    logic acc_clr;
    logic acc_wr;
    logic acc_rd;
    logic clr_last;

    // clear outranks write/read in the same cycle
    assign cmd_ok   = (state == IDLE) && chipselect;
    assign acc_clr  = cmd_ok && clear;
    assign acc_wr   = cmd_ok && write && !clear;
    assign acc_rd   = cmd_ok && read && !clear;
    assign clr_last = (state == CLEAR) && (&clr_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_clr) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (acc_wr) begin
            mem[address] <= I;
        end
    end

    // stage p1: registered read data; non-blocking update gives read-before-write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= acc_rd;
            if (acc_rd) rd_data_p1 <= mem[address];
        end
    end

    assign rd_valid = vld_p1;
    assign O        = chipselect ? rd_data_p1 : {WIDTH{1'bz}};

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];

    function automatic logic parity_of(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
            perr <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                par_mem[clr_cnt] <= 1'b0;
            end else if (acc_wr) begin
                par_mem[address] <= parity_of(I);
            end
            if (clr_last) begin
                perr <= 1'b0;
            end else if (acc_rd && (parity_of(mem[address]) != par_mem[address])) begin
                perr <= 1'b1;
            end
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule
